// File: rtl/lt24_pixel_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the LT24 pixel-write arbiter.
package lt24_pkg;

  localparam int unsigned LT24_WIDTH  = 240;
  localparam int unsigned LT24_HEIGHT = 320;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned PIX_W = 16;

  localparam logic [PIX_W-1:0] BLACK = 16'h0000;
  localparam logic [PIX_W-1:0] GREEN = 16'h07E0;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int unsigned w, input int unsigned h);
    return (32'(x) < w) && (32'(y) < h);
  endfunction

endpackage

// File: rtl/lt24_pixel_arbiter_if.sv
// Requester-side and display-side pixel bus shared by the render engines and the arbiter.
interface lt24_pixel_arbiter_if
  import lt24_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqLast;
  logic [NUM_REQ*X_W-1:0]   reqX;
  logic [NUM_REQ*Y_W-1:0]   reqY;
  logic [NUM_REQ*PIX_W-1:0] reqData;
  logic [NUM_REQ-1:0]       reqReady;

  logic [X_W-1:0]   xAddr;
  logic [Y_W-1:0]   yAddr;
  logic [PIX_W-1:0] pixelData;
  logic             pixelWrite;
  logic             pixelReady;

  modport master (
    output reqValid, reqLast, reqX, reqY, reqData, pixelReady,
    input  reqReady, xAddr, yAddr, pixelData, pixelWrite
  );

  modport slave (
    input  reqValid, reqLast, reqX, reqY, reqData, pixelReady,
    output reqReady, xAddr, yAddr, pixelData, pixelWrite
  );

endinterface

// File: rtl/lt24_pixel_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
module rr_select
  import lt24_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [idx_w(NUM_REQ)-1:0]   last_grant_i,
  output logic [idx_w(NUM_REQ)-1:0]   winner_o,
  output logic                        any_req_o
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner_o  = '0;
    any_req_o = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_i) + i) % NUM_REQ;
      if (!any_req_o && req_i[IdxW'(idx)]) begin
        winner_o  = IdxW'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lt24_pixel_arbiter.sv
// Burst-granular round-robin arbiter for the LT24 pixel-write port, with off-screen
// beat dropping and forced release of a stalled owner.
module lt24_pixel_arbiter
  import lt24_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = LT24_WIDTH,
  parameter int unsigned HEIGHT  = LT24_HEIGHT,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 globalResetn,
  lt24_pixel_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeoutErr,
  output logic [15:0]          dropCount
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  last_grant_q, last_grant_d;
  logic [CntW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic             timeout_err_q, timeout_err_d;

  logic [IdxW-1:0]  winner;
  logic             any_req;

  logic             own_valid;
  logic             own_last;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [PIX_W-1:0] own_data;
  logic             in_bnd;
  logic             accept;

  rr_select #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_select (
    .req_i       (bus.reqValid),
    .last_grant_i(last_grant_q),
    .winner_o    (winner),
    .any_req_o   (any_req)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_valid = bus.reqValid[i];
        own_last  = bus.reqLast[i];
        own_x     = bus.reqX[i*X_W +: X_W];
        own_y     = bus.reqY[i*Y_W +: Y_W];
        own_data  = bus.reqData[i*PIX_W +: PIX_W];
      end
    end
  end

  assign busy   = (state_q == StBurst);
  assign in_bnd = in_bounds(own_x, own_y, WIDTH, HEIGHT);
  // Off-screen beats are swallowed without waiting on the display.
  assign accept = busy && own_valid && (!in_bnd || bus.pixelReady);

  always_comb begin
    bus.pixelWrite = busy && own_valid && in_bnd;
    bus.xAddr      = busy ? own_x    : '0;
    bus.yAddr      = busy ? own_y    : '0;
    bus.pixelData  = busy ? own_data : '0;
    bus.reqReady   = '0;
    grant          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.reqReady[i] = accept && (owner_q == IdxW'(i));
      grant[i]        = busy && (owner_q == IdxW'(i));
    end
  end

  assign timeoutErr = timeout_err_q;
  assign dropCount  = drop_count_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    idle_cnt_d    = idle_cnt_q;
    drop_count_d  = drop_count_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StBurst;
          owner_d    = winner;
          idle_cnt_d = '0;
        end
      end
      StBurst: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (!in_bnd && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
          end
          if (own_last) begin
            state_d      = StIdle;
            last_grant_d = owner_q;
          end
        end else if (!own_valid) begin
          // Backpressure with valid held high never reaches this branch.
          if (idle_cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d       = StIdle;
            last_grant_d  = owner_q;
            idle_cnt_d    = '0;
            timeout_err_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge globalResetn) begin
    if (!globalResetn) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      idle_cnt_q    <= '0;
      drop_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      idle_cnt_q    <= idle_cnt_d;
      drop_count_q  <= drop_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Bench for lt24_pixel_arbiter: directed scenarios plus random bursts, all checked
// cycle by cycle against a burst-level reference model.
module tb_lt24_pixel_arbiter;
  import lt24_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 4;

  typedef struct {
    int          r;
    int          x;
    int          y;
    logic [15:0] d;
    bit          last;
    int          gap;
  } beat_t;

  logic        clock = 1'b0;
  logic        globalResetn = 1'b0;
  logic [N-1:0] grant;
  logic        busy;
  logic        timeoutErr;
  logic [15:0] dropCount;

  lt24_pixel_arbiter_if #(.NUM_REQ(N)) bus ();

  lt24_pixel_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (240),
    .HEIGHT (320),
    .TIMEOUT(TO)
  ) dut (
    .clock       (clock),
    .globalResetn(globalResetn),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .timeoutErr  (timeoutErr),
    .dropCount   (dropCount)
  );

  always #10 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  beat_t       q[$];
  bit          head_new[N];
  int          gap_left[N];
  logic        v[N];
  logic        l[N];
  int          x[N];
  int          y[N];
  logic [15:0] d[N];
  logic        pr;
  int          pr_mode;
  int          cyc;

  // reference model: owner -1 means no burst in progress
  int m_owner, m_last, m_idle, m_drops;
  bit m_terr;
  bit acc[N];

  // observations
  int writes_obs, terr_obs;
  int acks_obs[N];
  int grant_log[$];
  bit prev_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit inb(input int g);
    return (x[g] < 240) && (y[g] < 320);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_idle  = 0;
    m_drops = 0;
    m_terr  = 1'b0;
    prev_busy = 1'b0;
  endtask

  function automatic int head(input int r);
    for (int k = 0; k < q.size(); k++) if (q[k].r == r) return k;
    return -1;
  endfunction

  task automatic push(input int r, input int px, input int py, input logic [15:0] pd,
                      input bit last, input int gap);
    beat_t b;
    b.r = r; b.x = px; b.y = py; b.d = pd; b.last = last; b.gap = gap;
    q.push_back(b);
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.reqValid[i]          = v[i];
      bus.reqLast[i]           = l[i];
      bus.reqX[i*8 +: 8]       = 8'(x[i]);
      bus.reqY[i*9 +: 9]       = 9'(y[i]);
      bus.reqData[i*16 +: 16]  = d[i];
    end
    bus.pixelReady = pr;
  endtask

  task automatic drive();
    int h;
    cyc++;
    case (pr_mode)
      0:       pr = 1'b1;
      1:       pr = (cyc % 2 == 0);
      default: pr = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      h = head(i);
      v[i] = 1'b0;
      l[i] = 1'b0;
      if (h >= 0) begin
        if (head_new[i]) begin
          gap_left[i] = q[h].gap;
          head_new[i] = 1'b0;
        end
        if (gap_left[i] > 0) gap_left[i]--;
        else begin
          v[i] = 1'b1; l[i] = q[h].last; x[i] = q[h].x; y[i] = q[h].y; d[i] = q[h].d;
        end
      end
      if (!v[i]) begin
        x[i] = $urandom_range(0, 255); y[i] = $urandom_range(0, 511);
        d[i] = 16'($urandom);
      end
    end
    apply();
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_ready, e_grant;
    logic e_write;
    int ex, ey, ed, g;
    e_ready = '0; e_grant = '0; e_write = 1'b0; ex = 0; ey = 0; ed = 0;
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    if (m_owner >= 0) begin
      g = m_owner;
      e_grant[g] = 1'b1;
      e_write    = v[g] && inb(g);
      acc[g]     = v[g] && (!inb(g) || pr);
      e_ready[g] = acc[g];
      ex = x[g]; ey = y[g]; ed = int'(d[g]);
    end
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("reqReady", 32'(bus.reqReady), 32'(e_ready));
    check_eq("pixelWrite", 32'(bus.pixelWrite), 32'(e_write));
    check_eq("xAddr", 32'(bus.xAddr), ex);
    check_eq("yAddr", 32'(bus.yAddr), ey);
    check_eq("pixelData", 32'(bus.pixelData), ed);
    check_eq("timeoutErr", 32'(timeoutErr), 32'(m_terr));
    check_eq("dropCount", 32'(dropCount), m_drops);
    if (bus.pixelWrite === 1'b1) writes_obs++;
    if (timeoutErr === 1'b1) terr_obs++;
    for (int i = 0; i < N; i++) if (bus.reqReady[i] === 1'b1) acks_obs[i]++;
    if (busy === 1'b1 && !prev_busy) grant_log.push_back(int'(grant));
    prev_busy = (busy === 1'b1);
  endtask

  task automatic model_step();
    bit t;
    int c, g;
    t = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_owner < 0 && v[c]) m_owner = c;
      end
      m_idle = 0;
    end else begin
      g = m_owner;
      if (acc[g]) begin
        m_idle = 0;
        if (!inb(g) && m_drops < 65535) m_drops++;
        if (l[g]) begin m_last = g; m_owner = -1; end
      end else if (!v[g]) begin
        m_idle++;
        if (m_idle == TO) begin m_last = g; m_owner = -1; m_idle = 0; t = 1'b1; end
      end
    end
    m_terr = t;
  endtask

  task automatic cycle();
    @(negedge clock);
    check_cycle();
    model_step();
    for (int i = 0; i < N; i++) if (acc[i]) begin
      q.delete(head(i));
      head_new[i] = 1'b1;
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic run_drain(input int bound);
    int n;
    n = 0;
    while ((q.size() > 0 || m_owner >= 0) && n < bound) begin cycle(); n++; end
    check_eq("drain", 32'(q.size()) + 32'(m_owner >= 0), 0);
    cycle();
  endtask

  task automatic clear_stim();
    q.delete();
    for (int i = 0; i < N; i++) begin
      head_new[i] = 1'b1; gap_left[i] = 0; v[i] = 1'b0; l[i] = 1'b0;
      x[i] = 0; y[i] = 0; d[i] = '0;
    end
  endtask

  initial begin
    int w0, a0, t0, gl, len, r;
    cyc = 0; pr = 1'b1; pr_mode = 0;
    writes_obs = 0; terr_obs = 0;
    for (int i = 0; i < N; i++) acks_obs[i] = 0;
    clear_stim();
    model_reset();
    apply();
    #15;
    check_cycle();

    // contention: both requesters valid from reset
    for (int b = 0; b < 3; b++)
      for (int rq = 0; rq < N; rq++)
        for (int k = 0; k < 4; k++) push(rq, 10 * rq + k, b, 16'(rq * 256 + k), k == 3, 0);
    drive();
    @(posedge clock); #1;
    globalResetn = 1'b1;
    run_drain(200);
    for (int k = 0; k < 4; k++)
      check_eq("B_order", (k < grant_log.size()) ? grant_log[k] : -1, (k % 2 == 0) ? 1 : 2);

    // single requester, 64 beats
    w0 = writes_obs;
    for (int b = 0; b < 64; b++) push(0, b % 8, b / 8, GREEN, b == 63, 0);
    run_drain(300);
    check_eq("A_writes", writes_obs - w0, 64);
    check_eq("A_drops", 32'(dropCount), 0);

    // backpressure on a req1 burst
    pr_mode = 1;
    a0 = acks_obs[1]; t0 = terr_obs;
    for (int k = 0; k < 4; k++) push(1, 20 + k, 40, 16'hF800, k == 3, 0);
    run_drain(100);
    check_eq("C_acks", acks_obs[1] - a0, 4);
    check_eq("C_noterr", terr_obs - t0, 0);

    // off-screen beats
    pr_mode = 0;
    w0 = writes_obs; a0 = acks_obs[0];
    push(0, 239, 5, 16'h1234, 1'b0, 0);
    push(0, 240, 5, 16'h2345, 1'b0, 0);
    push(0, 10, 320, 16'h3456, 1'b1, 0);
    run_drain(100);
    check_eq("D_writes", writes_obs - w0, 1);
    check_eq("D_acks", acks_obs[0] - a0, 3);
    check_eq("D_drops", 32'(dropCount), 2);

    // timeout: req1 stalls mid-burst while req0 waits
    t0 = terr_obs; gl = grant_log.size();
    push(1, 5, 5, 16'hAAAA, 1'b0, 0);
    push(0, 6, 6, 16'h5555, 1'b1, 0);
    run_drain(100);
    check_eq("E_terr", terr_obs - t0, 1);
    check_eq("E_first", (gl < grant_log.size()) ? grant_log[gl] : -1, 2);
    check_eq("E_next", (gl + 1 < grant_log.size()) ? grant_log[gl + 1] : -1, 1);

    // reset in the middle of an 8-beat burst
    a0 = acks_obs[0];
    for (int k = 0; k < 8; k++) push(0, k, 100, 16'h0F0F, k == 7, 0);
    for (int n = 0; n < 30 && acks_obs[0] - a0 < 3; n++) cycle();
    check_eq("F_acks_before", acks_obs[0] - a0, 3);
    #4;
    globalResetn = 1'b0;
    #1;
    check_eq("F_pixelWrite", 32'(bus.pixelWrite), 0);
    check_eq("F_reqReady", 32'(bus.reqReady), 0);
    check_eq("F_grant", 32'(grant), 0);
    check_eq("F_busy", 32'(busy), 0);
    check_eq("F_drops", 32'(dropCount), 0);
    clear_stim();
    model_reset();
    apply();
    @(posedge clock); #1;
    gl = grant_log.size();
    push(1, 1, 1, 16'h1111, 1'b1, 0);
    push(0, 2, 2, 16'h2222, 1'b1, 0);
    drive();
    globalResetn = 1'b1;
    run_drain(100);
    check_eq("F_first", (gl < grant_log.size()) ? grant_log[gl] : -1, 1);

    // random bursts with random backpressure, gaps and off-screen beats
    pr_mode = 2;
    for (int b = 0; b < 80; b++) begin
      r   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        push(r,
             ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239),
             ($urandom_range(0, 9) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319),
             16'($urandom), k == len - 1,
             ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 1));
    end
    run_drain(20000);
    check_eq("R_drops", 32'(dropCount), m_drops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
